// File: rtl/cdb_arb_if.sv
// FU-to-arbiter handoff and CDB broadcast bundle.
// Handshake: FU i transfers when fu_valid[i] && fu_ready[i] at a rising clk
// edge. While fu_valid[i] is high and fu_ready[i] is low nothing is captured
// and the FU holds tag/rob/value steady. The CDB side has no ready: every
// slot with cdb_valid set is consumed in the cycle it is shown.
interface cdb_arb_if #(
  parameter int PRF_IDX = 6,
  parameter int ROB_IDX = 5,
  parameter int SCALAR  = 2,
  parameter int NUM_FU  = 3
);
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*PRF_IDX-1:0] fu_tag;
  logic [NUM_FU*ROB_IDX-1:0] fu_rob_idx;
  logic [NUM_FU*64-1:0]      fu_value;
  logic [NUM_FU-1:0]         fu_ready;
  logic [SCALAR-1:0]         cdb_valid;
  logic [SCALAR*PRF_IDX-1:0] cdb_tag;
  logic [SCALAR*ROB_IDX-1:0] cdb_rob_idx;
  logic [SCALAR*64-1:0]      cdb_value;

  // Functional-unit / bench side.
  modport master (
    output fu_valid, fu_tag, fu_rob_idx, fu_value,
    input  fu_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_value
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_tag, fu_rob_idx, fu_value,
    output fu_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_value
  );
endinterface

// File: rtl/cdb_arb.sv
// Common Data Bus arbiter/broadcaster. Each FU feeds a small skid FIFO; up to
// SCALAR FIFO heads are picked per cycle in round-robin order starting at
// rr_ptr and registered onto the CDB. fu_ready comes from registered counts
// only, so a pop in the same cycle never frees a slot early.
module cdb_arb #(
  parameter int PRF_IDX = 6,
  parameter int ROB_IDX = 5,
  parameter int SCALAR  = 2,
  parameter int NUM_FU  = 3,
  parameter int DEPTH   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  cdb_arb_if.slave bus,
  output logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] dbg_rr_ptr
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PRF_IDX-1:0] mem_tag   [NUM_FU][DEPTH];
  logic [ROB_IDX-1:0] mem_rob   [NUM_FU][DEPTH];
  logic [63:0]        mem_value [NUM_FU][DEPTH];

  logic [PTR_W-1:0] wr_ptr [NUM_FU];
  logic [PTR_W-1:0] rd_ptr [NUM_FU];
  logic [CNT_W-1:0] count  [NUM_FU];
  logic [RR_W-1:0]  rr_ptr;
  logic [RR_W-1:0]  rr_next;
  logic [RR_W-1:0]  fu_sel;

  logic [NUM_FU-1:0]  push;
  logic [NUM_FU-1:0]  pop;
  logic [SCALAR-1:0]  slot_vld;
  logic [PRF_IDX-1:0] slot_tag   [SCALAR];
  logic [ROB_IDX-1:0] slot_rob   [SCALAR];
  logic [63:0]        slot_value [SCALAR];
  int                 n_grant;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dbg_rr_ptr = rr_ptr;

  // Credit to each FU comes purely from the registered FIFO occupancy.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_ready[i] = (count[i] < CNT_W'(DEPTH));
      push[i]         = bus.fu_valid[i] && (count[i] < CNT_W'(DEPTH));
    end
  end

  // Round-robin pick: scan from rr_ptr, fill slots in order, one grant per FU.
  always_comb begin
    pop      = '0;
    slot_vld = '0;
    rr_next  = rr_ptr;
    fu_sel   = '0;
    n_grant  = 0;
    for (int s = 0; s < SCALAR; s++) begin
      slot_tag[s]   = '0;
      slot_rob[s]   = '0;
      slot_value[s] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      fu_sel = RR_W'((int'(rr_ptr) + k) % NUM_FU);
      if (count[fu_sel] != '0 && n_grant < SCALAR) begin
        pop[fu_sel] = 1'b1;
        for (int s = 0; s < SCALAR; s++) begin
          if (s == n_grant) begin
            slot_vld[s]   = 1'b1;
            slot_tag[s]   = mem_tag[fu_sel][rd_ptr[fu_sel]];
            slot_rob[s]   = mem_rob[fu_sel][rd_ptr[fu_sel]];
            slot_value[s] = mem_value[fu_sel][rd_ptr[fu_sel]];
          end
        end
        rr_next = RR_W'((int'(fu_sel) + 1) % NUM_FU);
        n_grant = n_grant + 1;
      end
    end
  end

  // FIFO payload storage; stale entries are harmless because pointers gate reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem_tag[i][wr_ptr[i]]   <= bus.fu_tag[i*PRF_IDX +: PRF_IDX];
        mem_rob[i][wr_ptr[i]]   <= bus.fu_rob_idx[i*ROB_IDX +: ROB_IDX];
        mem_value[i][wr_ptr[i]] <= bus.fu_value[i*64 +: 64];
      end
    end
  end

  // FIFO bookkeeping, round-robin pointer and registered CDB broadcast.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr          <= '0;
      bus.cdb_valid   <= '0;
      bus.cdb_tag     <= '0;
      bus.cdb_rob_idx <= '0;
      bus.cdb_value   <= '0;
    end else if (flush) begin
      // Squash drops every buffered result and any same-cycle push; payload
      // registers keep stale data that consumers ignore via cdb_valid.
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr        <= '0;
      bus.cdb_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      rr_ptr        <= rr_next;
      bus.cdb_valid <= slot_vld;
      for (int s = 0; s < SCALAR; s++) begin
        bus.cdb_tag[s*PRF_IDX +: PRF_IDX]     <= slot_tag[s];
        bus.cdb_rob_idx[s*ROB_IDX +: ROB_IDX] <= slot_rob[s];
        bus.cdb_value[s*64 +: 64]             <= slot_value[s];
      end
    end
  end
endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb: dut0 uses the default two-slot CDB, dut1 a
// single-slot CDB for the fairness scenario. Inputs change 1 time unit after
// the rising edge; outputs are sampled there as well.
module tb_cdb_arb;
  logic clk = 1'b0;
  logic reset;
  logic flush0;
  logic flush1;
  logic [1:0] rr0;
  logic [1:0] rr1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] exp_q [3][$];

  cdb_arb_if #(.PRF_IDX(6), .ROB_IDX(5), .SCALAR(2), .NUM_FU(3)) bus0 ();
  cdb_arb_if #(.PRF_IDX(6), .ROB_IDX(5), .SCALAR(1), .NUM_FU(3)) bus1 ();

  cdb_arb #(.PRF_IDX(6), .ROB_IDX(5), .SCALAR(2), .NUM_FU(3), .DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .bus(bus0), .dbg_rr_ptr(rr0)
  );

  cdb_arb #(.PRF_IDX(6), .ROB_IDX(5), .SCALAR(1), .NUM_FU(3), .DEPTH(2)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .bus(bus1), .dbg_rr_ptr(rr1)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] val_of(input logic [5:0] t);
    return 64'hC0DE_0000_0000_0000 | {58'd0, t};
  endfunction

  task automatic drv0(input int fu, input logic v, input logic [5:0] tag,
                      input logic [4:0] rob, input logic [63:0] val);
    bus0.fu_valid[fu]        = v;
    bus0.fu_tag[fu*6 +: 6]   = tag;
    bus0.fu_rob_idx[fu*5 +: 5] = rob;
    bus0.fu_value[fu*64 +: 64] = val;
  endtask

  task automatic drv1(input int fu, input logic v, input logic [5:0] tag,
                      input logic [4:0] rob, input logic [63:0] val);
    bus1.fu_valid[fu]        = v;
    bus1.fu_tag[fu*6 +: 6]   = tag;
    bus1.fu_rob_idx[fu*5 +: 5] = rob;
    bus1.fu_value[fu*64 +: 64] = val;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      drv0(i, 1'b0, 6'd0, 5'd0, 64'd0);
      drv1(i, 1'b0, 6'd0, 5'd0, 64'd0);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", bus0.cdb_valid);
    else n_pass++;
    n_checks++;
    if (bus0.fu_ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", bus0.fu_ready);
    else n_pass++;
    n_checks++;
    if (bus0.cdb_tag !== 12'd0 || bus0.cdb_rob_idx !== 10'd0 || bus0.cdb_value !== 128'd0)
      $display("FAIL reset_payload: got tag %h rob %h value %h want all zero",
               bus0.cdb_tag, bus0.cdb_rob_idx, bus0.cdb_value);
    else n_pass++;
    n_checks++;
    if (rr0 !== 2'd0) $display("FAIL reset_rr: got %0d want 0", rr0);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    drv0(0, 1'b1, 6'd5, 5'd3, 64'hAB);
    step();
    drv0(0, 1'b0, 6'd0, 5'd0, 64'd0);
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL single_early: got %b want 00", bus0.cdb_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b01 || bus0.cdb_tag[5:0] !== 6'd5 ||
        bus0.cdb_rob_idx[4:0] !== 5'd3 || bus0.cdb_value[63:0] !== 64'hAB)
      $display("FAIL single_bcast: got valid %b tag %0d rob %0d value %h want 01/5/3/ab",
               bus0.cdb_valid, bus0.cdb_tag[5:0], bus0.cdb_rob_idx[4:0], bus0.cdb_value[63:0]);
    else n_pass++;
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL single_once: got %b want 00", bus0.cdb_valid);
    else n_pass++;
  endtask

  task automatic test_contention();
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    n_checks++;
    if (rr0 !== 2'd0) $display("FAIL cont_rr_start: got %0d want 0", rr0);
    else n_pass++;
    drv0(0, 1'b1, 6'd1, 5'd0, 64'd1);
    drv0(1, 1'b1, 6'd2, 5'd1, 64'd2);
    drv0(2, 1'b1, 6'd3, 5'd2, 64'd3);
    step();
    idle_all();
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b11 || bus0.cdb_tag[5:0] !== 6'd1 || bus0.cdb_tag[11:6] !== 6'd2)
      $display("FAIL cont_first: got valid %b slot0 %0d slot1 %0d want 11/1/2",
               bus0.cdb_valid, bus0.cdb_tag[5:0], bus0.cdb_tag[11:6]);
    else n_pass++;
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b01 || bus0.cdb_tag[5:0] !== 6'd3)
      $display("FAIL cont_second: got valid %b slot0 %0d want 01/3",
               bus0.cdb_valid, bus0.cdb_tag[5:0]);
    else n_pass++;
    n_checks++;
    if (rr0 !== 2'd0) $display("FAIL cont_rr_end: got %0d want 0", rr0);
    else n_pass++;
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL cont_drained: got %b want 00", bus0.cdb_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int seq [3];
    int drops;
    int f;
    logic [5:0] t;
    logic [5:0] exp_t;
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    drops = 0;
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0;
      exp_q[i].delete();
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        if (bus0.cdb_valid[s]) begin
          f = int'(bus0.cdb_rob_idx[s*5 +: 5]);
          t = bus0.cdb_tag[s*6 +: 6];
          n_checks++;
          if (f > 2 || exp_q[f].size() == 0) begin
            $display("FAIL bp_spurious slot%0d: got tag %h rob %0d want no broadcast", s, t, f);
          end else begin
            exp_t = exp_q[f].pop_front();
            if (t !== exp_t || bus0.cdb_value[s*64 +: 64] !== val_of(exp_t))
              $display("FAIL bp_order slot%0d fu%0d: got tag %h value %h want tag %h value %h",
                       s, f, t, bus0.cdb_value[s*64 +: 64], exp_t, val_of(exp_t));
            else n_pass++;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (bus0.fu_ready[i] !== (exp_q[i].size() < 2))
          $display("FAIL bp_ready fu%0d cyc%0d: got %b want %b (occupancy %0d)",
                   i, cyc, bus0.fu_ready[i], (exp_q[i].size() < 2), exp_q[i].size());
        else n_pass++;
      end
      if (bus0.fu_ready[1] === 1'b0) drops++;
      for (int i = 0; i < 3; i++) begin
        if (cyc < 30) begin
          t = 6'((i << 4) | (seq[i] & 15));
          drv0(i, 1'b1, t, 5'(i), val_of(t));
          if (bus0.fu_ready[i]) begin
            exp_q[i].push_back(t);
            seq[i]++;
          end
        end else begin
          drv0(i, 1'b0, 6'd0, 5'd0, 64'd0);
        end
      end
      step();
    end
    n_checks++;
    if (drops == 0) $display("FAIL bp_ready_drop: got %0d stalled cycles on fu1 want >0", drops);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (exp_q[i].size() != 0)
        $display("FAIL bp_lost fu%0d: got %0d results never broadcast want 0", i, exp_q[i].size());
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    int seq [3];
    logic [5:0] t;
    logic [5:0] exp_t;
    int want_fu;
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0;
      exp_q[i].delete();
    end
    for (int cyc = 0; cyc < 11; cyc++) begin
      for (int i = 0; i < 3; i += 2) begin
        t = 6'((i << 4) | (seq[i] & 15));
        drv1(i, 1'b1, t, 5'(i), val_of(t));
        if (bus1.fu_ready[i]) begin
          exp_q[i].push_back(t);
          seq[i]++;
        end
      end
      step();
      if (cyc > 0) begin
        want_fu = ((cyc - 1) % 2 == 0) ? 0 : 2;
        exp_t = (exp_q[want_fu].size() != 0) ? exp_q[want_fu].pop_front() : 6'h3F;
        n_checks++;
        if (bus1.cdb_valid !== 1'b1 || int'(bus1.cdb_rob_idx) != want_fu || bus1.cdb_tag !== exp_t)
          $display("FAIL fair_grant cyc%0d: got valid %b fu %0d tag %h want 1/%0d/%h",
                   cyc, bus1.cdb_valid, bus1.cdb_rob_idx, bus1.cdb_tag, want_fu, exp_t);
        else n_pass++;
      end
    end
    idle_all();
    repeat (4) step();
  endtask

  task automatic test_flush();
    logic [5:0] t;
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        t = 6'((i << 4) | cyc);
        drv0(i, 1'b1, t, 5'(i), val_of(t));
      end
      step();
    end
    n_checks++;
    if (bus0.fu_ready !== 3'b110) $display("FAIL flush_pre_ready: got %b want 110", bus0.fu_ready);
    else n_pass++;
    drv0(0, 1'b0, 6'd0, 5'd0, 64'd0);
    drv0(1, 1'b0, 6'd0, 5'd0, 64'd0);
    drv0(2, 1'b1, 6'h3F, 5'd2, val_of(6'h3F));
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    idle_all();
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL flush_valid: got %b want 00", bus0.cdb_valid);
    else n_pass++;
    n_checks++;
    if (bus0.fu_ready !== 3'b111) $display("FAIL flush_ready: got %b want 111", bus0.fu_ready);
    else n_pass++;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      n_checks++;
      if (bus0.cdb_valid !== 2'b00)
        $display("FAIL flush_dropped cyc%0d: got valid %b tag %h want 00", cyc, bus0.cdb_valid, bus0.cdb_tag);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    drv0(0, 1'b1, 6'h11, 5'd0, val_of(6'h11));
    drv0(1, 1'b1, 6'h12, 5'd1, val_of(6'h12));
    step();
    drv0(0, 1'b1, 6'h13, 5'd0, val_of(6'h13));
    drv0(1, 1'b1, 6'h14, 5'd1, val_of(6'h14));
    step();
    idle_all();
    n_checks++;
    if (bus0.cdb_valid !== 2'b11 || bus0.cdb_tag !== {6'h12, 6'h11})
      $display("FAIL areset_pre: got valid %b tags %h want 11/%h", bus0.cdb_valid, bus0.cdb_tag, {6'h12, 6'h11});
    else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus0.cdb_valid !== 2'b00 || bus0.cdb_tag !== 12'd0)
      $display("FAIL areset_immediate: got valid %b tag %h want 00/000", bus0.cdb_valid, bus0.cdb_tag);
    else n_pass++;
    n_checks++;
    if (bus0.fu_ready !== 3'b111) $display("FAIL areset_ready: got %b want 111", bus0.fu_ready);
    else n_pass++;
    #2;
    reset = 1'b0;
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b00) $display("FAIL areset_dropped: got %b want 00", bus0.cdb_valid);
    else n_pass++;
    drv0(2, 1'b1, 6'h2A, 5'd7, 64'h55);
    step();
    idle_all();
    step();
    n_checks++;
    if (bus0.cdb_valid !== 2'b01 || bus0.cdb_tag[5:0] !== 6'h2A ||
        bus0.cdb_rob_idx[4:0] !== 5'd7 || bus0.cdb_value[63:0] !== 64'h55)
      $display("FAIL areset_recover: got valid %b tag %h rob %0d value %h want 01/2a/7/55",
               bus0.cdb_valid, bus0.cdb_tag[5:0], bus0.cdb_rob_idx[4:0], bus0.cdb_value[63:0]);
    else n_pass++;
  endtask

  // Sequencer and final report
  initial begin
    reset  = 1'b1;
    flush0 = 1'b0;
    flush1 = 1'b0;
    idle_all();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_fairness();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
